// File: rtl/nubus_slot_master.sv
// Slot-bus initiator: turns a qualified CPU cycle into one select/ack transaction and synchronises nmrq_n.
// Define NUBUS_SLOT_TIMEOUT_EN to enable the bus-error timeout and post-abort recovery counting.
module nubus_slot_master #(
  parameter logic [3:0] SLOT_ID = 4'h9,
  parameter int         TIMEOUT = 255,
  parameter int         RECOVER = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_req,
  input  logic [23:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  input  logic        cpu_uds_n,
  input  logic        cpu_lds_n,
  input  logic        cpu_rw_n,
  output logic        cpu_dtack_n,
  output logic        cpu_berr_n,
  output logic [31:0] nb_addr,
  output logic [15:0] nb_wdata,
  input  logic [15:0] nb_rdata,
  output logic [1:0]  nb_uds_lds,
  output logic        nb_rw_n,
  output logic        nb_select,
  input  logic        nb_ack_n,
  input  logic        nb_nmrq_n,
  output logic        slot_irq_n,
  output logic        busy
);

  localparam int CNT_MAX = (TIMEOUT > RECOVER) ? TIMEOUT : RECOVER;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(CNT_MAX);
`ifdef NUBUS_SLOT_TIMEOUT_EN
  localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_REC = CNT_W'(RECOVER);
`endif

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_ACK = 3'd1,
    S_DONE     = 3'd2,
    S_RELEASE  = 3'd3,
    S_ABORT    = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [31:0]      addr_q, addr_d;
  logic [15:0]      wdata_q, wdata_d;
  logic [1:0]       lanes_q, lanes_d;
  logic             rw_n_q, rw_n_d;
  logic             sel_q, sel_d;
  logic [15:0]      rdata_q, rdata_d;
  logic             dtack_n_q, dtack_n_d;
  logic             berr_n_q, berr_n_d;
  logic             irq_meta_q, irq_sync_q;
  logic [1:0]       req_lanes;

  assign req_lanes = ~{cpu_uds_n, cpu_lds_n};
  assign cnt_inc   = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    lanes_d   = lanes_q;
    rw_n_d    = rw_n_q;
    sel_d     = sel_q;
    rdata_d   = rdata_q;
    dtack_n_d = dtack_n_q;
    berr_n_d  = berr_n_q;

    case (state_q)
      S_IDLE: begin
        if (cpu_req) begin
          addr_d  = {4'hF, SLOT_ID, cpu_addr};
          wdata_d = cpu_wdata;
          lanes_d = req_lanes;
          rw_n_d  = cpu_rw_n;
          if (req_lanes == 2'b00) begin
            rdata_d   = 16'h0000;
            dtack_n_d = 1'b0;
            state_d   = S_DONE;
          end else if (nb_ack_n) begin
            // A card still holding ack from a prior cycle must release before a new select edge.
            sel_d   = 1'b1;
            cnt_d   = '0;
            state_d = S_WAIT_ACK;
          end
        end
      end

      S_WAIT_ACK: begin
        if (!nb_ack_n) begin
          sel_d     = 1'b0;
          dtack_n_d = 1'b0;
          if (rw_n_q) rdata_d = nb_rdata;
          state_d   = S_DONE;
        end else if (!cpu_req) begin
          sel_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_ABORT;
`ifdef NUBUS_SLOT_TIMEOUT_EN
        end else if (cnt_inc == CNT_TO) begin
          sel_d    = 1'b0;
          berr_n_d = 1'b0;
          cnt_d    = '0;
          state_d  = S_ABORT;
`endif
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_DONE: begin
        if (!cpu_req) begin
          dtack_n_d = 1'b1;
          state_d   = S_RELEASE;
        end
      end

      S_RELEASE: begin
        if (nb_ack_n) state_d = S_IDLE;
      end

      S_ABORT: begin
`ifdef NUBUS_SLOT_TIMEOUT_EN
        // BERR low marks the not-yet-released phase; recovery counting starts once it is gone,
        // so a follow-on request raised during recovery is simply held off.
        if (!berr_n_q) begin
          cnt_d = '0;
          if (!cpu_req) berr_n_d = 1'b1;
        end else if (!nb_ack_n) begin
          cnt_d = '0;
        end else if (cnt_inc == CNT_REC) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
`else
        if (nb_ack_n) state_d = S_IDLE;
`endif
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= 32'h0;
      wdata_q   <= 16'h0;
      lanes_q   <= 2'b00;
      rw_n_q    <= 1'b1;
      sel_q     <= 1'b0;
      rdata_q   <= 16'h0;
      dtack_n_q <= 1'b1;
      berr_n_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      lanes_q   <= lanes_d;
      rw_n_q    <= rw_n_d;
      sel_q     <= sel_d;
      rdata_q   <= rdata_d;
      dtack_n_q <= dtack_n_d;
      berr_n_q  <= berr_n_d;
    end
  end

  // Two-flop synchroniser for the card interrupt, independent of the transaction FSM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_meta_q <= 1'b1;
      irq_sync_q <= 1'b1;
    end else begin
      irq_meta_q <= nb_nmrq_n;
      irq_sync_q <= irq_meta_q;
    end
  end

  assign nb_addr     = addr_q;
  assign nb_wdata    = wdata_q;
  assign nb_uds_lds  = lanes_q;
  assign nb_rw_n     = rw_n_q;
  assign nb_select   = sel_q;
  assign cpu_rdata   = rdata_q;
  assign cpu_dtack_n = dtack_n_q;
  assign cpu_berr_n  = berr_n_q;
  assign slot_irq_n  = irq_sync_q;
  assign busy        = (state_q != S_IDLE);

endmodule
